// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Assembles big-endian instruction words from a serial byte
//               stream and writes them to instruction memory at consecutive
//               word addresses. The program counter is held in reset while
//               loading. A load ends on the HALT word (all ones, which is
//               itself written) or abnormally when the last memory address
//               has been written without seeing HALT.
//
// Ports       : i_clock, i_reset       clock, async active-high reset
//               i_start                single-cycle load request
//               i_rx_data, i_rx_valid  received byte and its strobe
//               o_write_enable/addr/data  instruction-memory write port
//               o_pc_reset, o_loading  high while a load is in progress
//               o_done, o_error        load finished / finished abnormally
//
// Options     : LOADER_CHECKSUM_EN - after HALT, one extra byte is received
//               and compared with the XOR of every preceding byte of the load;
//               a difference is reported through o_error.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
    parameter int NB_PC          = 6,
    parameter int NB_INSTRUCTION = 32,
    parameter int NB_DATA        = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_DATA-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_write_enable,
    output logic [NB_PC-1:0]          o_write_addr,
    output logic [NB_INSTRUCTION-1:0] o_write_data,
    output logic                      o_pc_reset,
    output logic                      o_loading,
    output logic                      o_done,
    output logic                      o_error
);

    localparam int BYTES_PER_WORD = NB_INSTRUCTION / NB_DATA;
    localparam int NB_CNT         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [NB_CNT-1:0]         LAST_BYTE = NB_CNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_INSTRUCTION-1:0] HALT_WORD = '1;
    localparam logic [NB_PC-1:0]          LAST_ADDR = '1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3
    } state_t;
`endif

    state_t                      state;
    state_t                      state_next;
    logic [NB_CNT-1:0]           byte_cnt;
    logic [NB_PC-1:0]            addr;
    logic [NB_INSTRUCTION-1:0]   word;
    logic                        error;
`ifdef LOADER_CHECKSUM_EN
    logic [NB_DATA-1:0]          xor_acc;
`endif

    logic accept_last;
    logic is_halt;
    logic addr_full;

    assign accept_last = i_rx_valid && (byte_cnt == LAST_BYTE);
    assign is_halt     = (word == HALT_WORD);
    assign addr_full   = (addr == LAST_ADDR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (i_start)     state_next = ST_RECEIVE;
            ST_RECEIVE: if (accept_last) state_next = ST_WRITE;
            ST_WRITE: begin
                if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end else if (addr_full) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RECEIVE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:   if (i_rx_valid)  state_next = ST_DONE;
`endif
            ST_DONE:    if (i_start)     state_next = ST_RECEIVE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte assembly, word address, completion status
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt <= '0;
            addr     <= '0;
            word     <= '0;
            error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        byte_cnt <= '0;
                        addr     <= '0;
                        word     <= '0;
                        error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc  <= '0;
`endif
                    end
                end
                ST_RECEIVE: begin
                    if (i_rx_valid) begin
                        // Shift left so the first byte ends in the MSBs.
                        word     <= {word[NB_INSTRUCTION-NB_DATA-1:0], i_rx_data};
                        byte_cnt <= accept_last ? '0 : byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc  <= xor_acc ^ i_rx_data;
`endif
                    end
                end
                ST_WRITE: begin
                    if (is_halt) begin
                        error <= 1'b0;
                    end else if (addr_full) begin
                        // Memory full without HALT: stop, do not wrap.
                        error <= 1'b1;
                    end else begin
                        addr  <= addr + 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (i_rx_valid) begin
                        error <= (i_rx_data != xor_acc);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_write_enable = (state == ST_WRITE);
    assign o_write_addr   = addr;
    assign o_write_data   = word;
    assign o_loading      = (state != ST_IDLE) && (state != ST_DONE);
    assign o_pc_reset     = o_loading;
    assign o_done         = (state == ST_DONE);
    assign o_error        = error;

endmodule
`default_nettype wire
